// File: rtl/decompressor.sv
// decompressor: expands one zero-chunk compressed page into 64 lines.
// Optional macro HACD_DECOMP_META_CHECK_EN enables metadata validation.
module decompressor #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  decomp_start,
  input  logic                  rdfifo_empty,
  output logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [1:0]            rd_rresp,
  input  logic                  rd_valid,
  input  logic                  wrfifo_full,
  output logic                  wr_req,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  decomp_done,
  output logic                  meta_err,
  output logic                  bus_err,
  output logic [6:0]            line_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    RD_META,
    CHECK_META,
    EXPAND,
    DONE,
    BUS_ERROR
  } state_e;

  state_e                state_q;
  logic                  rd_req_q;
  logic                  wr_req_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  done_q;
  logic                  meta_err_q;
  logic                  bus_err_q;
  logic [6:0]            line_cnt_q;
  logic                  out_q;
  logic                  meta_ok_q;
  logic [3:0]            vec_q;
  logic [1:0]            data_chunk_q;

  logic                  resp_ok;
  logic                  rd_ok;
  logic                  in_data;
  logic                  next_in_data;
  logic                  meta_ok_c;
  logic [6:0]            cnt_inc;
  logic [1:0]            first_data;

  assign resp_ok = (rd_rresp == 2'b00);
  assign rd_ok   = !rdfifo_empty && !wrfifo_full;
  assign cnt_inc = line_cnt_q + 7'd1;
  assign in_data = (line_cnt_q[5:4] == data_chunk_q);
  assign next_in_data = !cnt_inc[6] &&
                        (cnt_inc[5:4] == data_chunk_q);

`ifdef HACD_DECOMP_META_CHECK_EN
  logic [2:0] vec_pop;
  assign vec_pop = 3'(rd_data[0]) + 3'(rd_data[1]) +
                   3'(rd_data[2]) + 3'(rd_data[3]);
  assign meta_ok_c = (rd_data[DATA_WIDTH-1:4] == '0) &&
                     (vec_pop >= 3'd3);
`else
  assign meta_ok_c = 1'b1;
`endif

  // Lowest chunk not flagged zero holds the data; all-zero vec maps to 0.
  always_comb begin
    first_data = 2'd0;
    if (!vec_q[0]) begin
      first_data = 2'd0;
    end else if (!vec_q[1]) begin
      first_data = 2'd1;
    end else if (!vec_q[2]) begin
      first_data = 2'd2;
    end else if (!vec_q[3]) begin
      first_data = 2'd3;
    end
  end

  // Page expansion FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      meta_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      line_cnt_q   <= '0;
      out_q        <= 1'b0;
      meta_ok_q    <= 1'b0;
      vec_q        <= '0;
      data_chunk_q <= '0;
    end else begin
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      meta_err_q <= 1'b0;
      if (rd_valid) begin
        out_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (decomp_start && !rdfifo_empty) begin
            line_cnt_q <= '0;
            state_q    <= RD_META;
          end
        end
        RD_META: begin
          if (rd_valid) begin
            if (resp_ok) begin
              vec_q     <= rd_data[3:0];
              meta_ok_q <= meta_ok_c;
              state_q   <= CHECK_META;
            end else begin
              bus_err_q <= 1'b1;
              state_q   <= BUS_ERROR;
            end
          end else if (rd_ok && !out_q) begin
            rd_req_q <= 1'b1;
            out_q    <= 1'b1;
          end
        end
        CHECK_META: begin
          data_chunk_q <= first_data;
          if (!meta_ok_q) begin
            meta_err_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          if (line_cnt_q[6]) begin
            done_q  <= decomp_start;
            state_q <= DONE;
          end else if (!in_data) begin
            if (!wrfifo_full) begin
              wr_req_q   <= 1'b1;
              wr_data_q  <= '0;
              line_cnt_q <= cnt_inc;
            end
          end else if (rd_valid) begin
            if (!resp_ok) begin
              bus_err_q <= 1'b1;
              state_q   <= BUS_ERROR;
            end else begin
              wr_req_q   <= 1'b1;
              wr_data_q  <= rd_data;
              line_cnt_q <= cnt_inc;
              // Returning line retires the outstanding read.
              if (rd_ok && next_in_data) begin
                rd_req_q <= 1'b1;
                out_q    <= 1'b1;
              end
            end
          end else if (rd_ok && !out_q) begin
            rd_req_q <= 1'b1;
            out_q    <= 1'b1;
          end
        end
        DONE: begin
          if (!decomp_start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        BUS_ERROR: begin
          bus_err_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_req      = rd_req_q;
  assign wr_req      = wr_req_q;
  assign wr_data     = wr_data_q;
  assign decomp_done = done_q;
  assign meta_err    = meta_err_q;
  assign bus_err     = bus_err_q;
  assign line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_decompressor.sv
// tb_decompressor: scoreboard bench for the page decompressor.
// Read FIFO model on negedge, push monitor pops expected lines.
module tb_decompressor;
  localparam int W = 512;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         decomp_start = 1'b0;
  logic         rdfifo_empty = 1'b1;
  logic         rd_req;
  logic [W-1:0] rd_data = '0;
  logic [1:0]   rd_rresp = 2'd0;
  logic         rd_valid = 1'b0;
  logic         wrfifo_full = 1'b0;
  logic         wr_req;
  logic [W-1:0] wr_data;
  logic         decomp_done;
  logic         meta_err;
  logic         bus_err;
  logic [6:0]   line_cnt;

  decompressor #(.DATA_WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .decomp_start (decomp_start),
    .rdfifo_empty (rdfifo_empty),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_rresp     (rd_rresp),
    .rd_valid     (rd_valid),
    .wrfifo_full  (wrfifo_full),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .decomp_done  (decomp_done),
    .meta_err     (meta_err),
    .bus_err      (bus_err),
    .line_cnt     (line_cnt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]   resp;
    logic [W-1:0] data;
  } rd_ent_t;

  rd_ent_t      rdq[$];
  logic [W-1:0] exp_q[$];
  rd_ent_t      pend;
  logic [W-1:0] e;
  int total = 0;
  int passed = 0;
  int pops = 0;
  int pushes = 0;
  int cyc = 0;
  int rd_lat = 1;
  int pend_cnt = 0;
  bit tog = 1'b0;
  logic full_seen = 1'b0;

  function automatic logic [W-1:0] pat(input int v);
    logic [31:0] w;
    w = 32'(v);
    return {(W/32){w}};
  endfunction

  function automatic int dchunk(input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (!v[k]) return k;
    return 0;
  endfunction

  // Read FIFO model and backpressure pattern.
  always @(negedge clk_i) begin
    cyc++;
    rd_valid = 1'b0;
    if (!rst_ni) begin
      pend_cnt = 0;
    end else begin
      if (rd_req) begin
        pops++;
        if (rdq.size() > 0) begin
          pend = rdq.pop_front();
        end else begin
          pend.resp = 2'd0;
          pend.data = '0;
          total++;
          $display("FAIL pop_empty: got pop, want none");
        end
        pend_cnt = rd_lat;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = pend.data;
          rd_rresp = pend.resp;
        end
      end
    end
    rdfifo_empty = (rdq.size() == 0);
    wrfifo_full  = tog && ((cyc / 3) % 2 == 1);
  end

  always @(posedge clk_i) full_seen <= wrfifo_full;

  // Push monitor: compare every pushed line with the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && wr_req) begin
      pushes++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL push_extra: got push %0d, want none", pushes);
      end else begin
        e = exp_q.pop_front();
        if (wr_data === e) passed++;
        else $display("FAIL line%0d: got %h want %h",
                      pushes - 1, wr_data, e);
      end
      if (wr_data == '0) begin
        total++;
        if (!full_seen) passed++;
        else $display("FAIL zero_push_full: got full=1, want 0");
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic load_page(input logic [3:0] vec, input int base,
                           input int err_at, input int ndata);
    rd_ent_t t;
    t.resp = 2'd0;
    t.data = '0;
    t.data[3:0] = vec;
    rdq.push_back(t);
    for (int i = 0; i < ndata; i++) begin
      t.resp = (i == err_at) ? 2'd2 : 2'd0;
      t.data = pat(base + i + 1);
      rdq.push_back(t);
    end
  endtask

  task automatic exp_page(input logic [3:0] vec, input int base,
                          input int n);
    int dc;
    dc = dchunk(vec);
    for (int l = 0; l < n; l++)
      exp_q.push_back((l / 16 == dc) ? pat(base + l % 16 + 1) : '0);
  endtask

  task automatic wait_sig(input int sel, input int max);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk_i);
      case (sel)
        0: hit = decomp_done;
        1: hit = bus_err;
        2: hit = meta_err;
        default: hit = (line_cnt == 7'd30);
      endcase
    end
    if (!hit) begin
      total++;
      $display("FAIL timeout_%0d: got none in %0d cycles, want event",
               sel, max);
    end
  endtask

  task automatic run_page(input string nm, input logic [3:0] vec,
                          input int base);
    pops = 0;
    pushes = 0;
    load_page(vec, base, -1, 16);
    exp_page(vec, base, 64);
    decomp_start = 1'b1;
    wait_sig(0, 3000);
    chk({nm, "_done"}, 32'(decomp_done), 1);
    chk({nm, "_cnt"}, 32'(line_cnt), 64);
    chk({nm, "_pops"}, pops, 17);
    chk({nm, "_pushes"}, pushes, 64);
    chk({nm, "_left"}, exp_q.size(), 0);
    decomp_start = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk({nm, "_done_drop"}, 32'(decomp_done), 0);
    rdq.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_req"}, 32'(rd_req), 0);
    chk({nm, "_wr_req"}, 32'(wr_req), 0);
    chk({nm, "_wr_data"}, 32'(wr_data != '0), 0);
    chk({nm, "_done"}, 32'(decomp_done), 0);
    chk({nm, "_meta"}, 32'(meta_err), 0);
    chk({nm, "_bus"}, 32'(bus_err), 0);
    chk({nm, "_cnt"}, 32'(line_cnt), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk_zero("rst");
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_page("p1110", 4'b1110, 0);
    rd_lat = 2;
    run_page("p1111", 4'hF, 100);
    rd_lat = 1;
    tog = 1'b1;
    run_page("p0111", 4'b0111, 200);
    tog = 1'b0;

    pops = 0;
    pushes = 0;
    load_page(4'b1110, 300, 4, 16);
    exp_page(4'b1110, 300, 4);
    decomp_start = 1'b1;
    wait_sig(1, 500);
    repeat (20) @(negedge clk_i);
    chk("berr_bus", 32'(bus_err), 1);
    chk("berr_done", 32'(decomp_done), 0);
    chk("berr_pushes", pushes, 4);
    chk("berr_pops", pops, 6);
    chk("berr_cnt", 32'(line_cnt), 4);
    decomp_start = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("berr_sticky", 32'(bus_err), 1);
    rst_ni = 1'b0;
    #1;
    chk("berr_rst", 32'(bus_err), 0);
    rdq.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

`ifdef HACD_DECOMP_META_CHECK_EN
    pops = 0;
    pushes = 0;
    load_page(4'b1100, 400, -1, 0);
    decomp_start = 1'b1;
    wait_sig(2, 200);
    chk("meta_err", 32'(meta_err), 1);
    chk("meta_pops", pops, 1);
    @(negedge clk_i);
    chk("meta_pulse", 32'(meta_err), 0);
    repeat (4) @(negedge clk_i);
    chk("meta_pushes", pushes, 0);
    chk("meta_cnt", 32'(line_cnt), 0);
    decomp_start = 1'b0;
    @(negedge clk_i);
`else
    run_page("p1100", 4'b1100, 400);
`endif

    pops = 0;
    pushes = 0;
    load_page(4'b1110, 500, -1, 16);
    exp_page(4'b1110, 500, 64);
    decomp_start = 1'b1;
    wait_sig(3, 500);
    rst_ni = 1'b0;
    #1;
    chk_zero("midrst");
    decomp_start = 1'b0;
    rdq.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_page("fresh", 4'b1011, 600);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
